// File: rtl/ocx_tlx_resp_fifo_cmt.sv
// TLX response FIFO with commit/rollback on bookend and CRC error, AFU credit
// gating on the read side and host credit return for every freed entry.
module ocx_tlx_resp_fifo_cmt #(
    parameter int DATA_WIDTH   = 56,
    parameter int ADDR_WIDTH   = 7,
    parameter int CREDIT_WIDTH = 7
) (
    input  logic                    tlx_clk,
    input  logic                    reset_n,
    input  logic                    wr_valid,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    commit,
    input  logic                    crc_error,
    input  logic [CREDIT_WIDTH-1:0] afu_tlx_resp_initial_credit,
    input  logic                    afu_tlx_resp_credit,
    output logic                    tlx_afu_valid,
    output logic [DATA_WIDTH-1:0]   tlx_afu_resp_data,
    output logic                    rcv_xmt_credit_v,
    output logic [ADDR_WIDTH:0]     occupancy,
    output logic                    fifo_overflow_err,
    output logic                    credit_overflow_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]     DEPTH_P  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = {CREDIT_WIDTH{1'b1}};
    localparam logic [CREDIT_WIDTH-1:0] CRED_ONE = {{(CREDIT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]     commit_ptr_q, commit_ptr_d;
    logic [ADDR_WIDTH:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     ret_cnt_q, ret_cnt_d;
    logic [CREDIT_WIDTH-1:0] afu_cred_q, afu_cred_d;
    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic                    cred_v_q;
    logic                    fifo_ovf_q, fifo_ovf_d;
    logic                    cred_ovf_q, cred_ovf_d;

    logic                    full_s;
    logic                    readable_s;
    logic                    rd_ena_s;
    logic                    wr_accept_s;
    logic                    ret_nz_s;
    logic [ADDR_WIDTH:0]     wr_post_s;

    assign full_s      = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
    assign readable_s  = (commit_ptr_q != rd_ptr_q);
    assign rd_ena_s    = readable_s && (afu_cred_q != {CREDIT_WIDTH{1'b0}});
    assign wr_accept_s = wr_valid && !full_s && !crc_error;
    assign ret_nz_s    = (ret_cnt_q != {(ADDR_WIDTH+1){1'b0}});
    assign wr_post_s   = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_accept_s};

    // Next-state for pointers, credit counters and sticky errors
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        afu_cred_d   = afu_cred_q;
        cred_ovf_d   = cred_ovf_q;

        // A CRC error rolls back to the last bookend and beats a same-cycle commit
        if (crc_error) begin
            wr_ptr_d     = commit_ptr_q;
            commit_ptr_d = commit_ptr_q;
        end else begin
            wr_ptr_d = wr_post_s;
            if (commit) begin
                commit_ptr_d = wr_post_s;
            end else begin
                commit_ptr_d = commit_ptr_q;
            end
        end

        rd_ptr_d   = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_ena_s};
        fifo_ovf_d = fifo_ovf_q | (wr_valid & full_s);

        case ({afu_tlx_resp_credit, rd_ena_s})
            2'b10: begin
                if (afu_cred_q == CRED_MAX) begin
                    afu_cred_d = afu_cred_q;
                    cred_ovf_d = 1'b1;
                end else begin
                    afu_cred_d = afu_cred_q + CRED_ONE;
                end
            end
            2'b01:   afu_cred_d = afu_cred_q - CRED_ONE;
            default: afu_cred_d = afu_cred_q;
        endcase

        ret_cnt_d = ret_cnt_q + {{ADDR_WIDTH{1'b0}}, rd_ena_s}
                              - {{ADDR_WIDTH{1'b0}}, ret_nz_s};
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge tlx_clk) begin
        if (!reset_n) begin
            wr_ptr_q     <= {(ADDR_WIDTH+1){1'b0}};
            commit_ptr_q <= {(ADDR_WIDTH+1){1'b0}};
            rd_ptr_q     <= {(ADDR_WIDTH+1){1'b0}};
            ret_cnt_q    <= DEPTH_P;
            afu_cred_q   <= afu_tlx_resp_initial_credit;
            valid_q      <= 1'b0;
            resp_data_q  <= {DATA_WIDTH{1'b0}};
            cred_v_q     <= 1'b0;
            fifo_ovf_q   <= 1'b0;
            cred_ovf_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ret_cnt_q    <= ret_cnt_d;
            afu_cred_q   <= afu_cred_d;
            valid_q      <= rd_ena_s;
            cred_v_q     <= ret_nz_s;
            fifo_ovf_q   <= fifo_ovf_d;
            cred_ovf_q   <= cred_ovf_d;
            if (rd_ena_s) begin
                resp_data_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            end
        end
    end

    // Entry storage; contents need no reset since pointers gate visibility
    always_ff @(posedge tlx_clk) begin
        if (reset_n && wr_accept_s) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    assign tlx_afu_valid       = valid_q;
    assign tlx_afu_resp_data   = resp_data_q;
    assign rcv_xmt_credit_v    = cred_v_q;
    assign occupancy           = wr_ptr_q - rd_ptr_q;
    assign fifo_overflow_err   = fifo_ovf_q;
    assign credit_overflow_err = cred_ovf_q;

endmodule

// File: tb/tb_ocx_tlx_resp_fifo_cmt.sv
// Self-checking bench for ocx_tlx_resp_fifo_cmt: a queue-based reference model
// checked every cycle, a vector table for commit/rollback, and directed corners.
module tb_ocx_tlx_resp_fifo_cmt;

    localparam int DW    = 56;
    localparam int AW    = 7;
    localparam int CW    = 7;
    localparam int DEPTH = 128;
    localparam int CMAX  = 127;

    logic          tlx_clk = 1'b0;
    logic          reset_n;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          commit;
    logic          crc_error;
    logic [CW-1:0] init_cred;
    logic          afu_ret;
    logic          tlx_afu_valid;
    logic [DW-1:0] tlx_afu_resp_data;
    logic          rcv_xmt_credit_v;
    logic [AW:0]   occupancy;
    logic          fifo_overflow_err;
    logic          credit_overflow_err;

    ocx_tlx_resp_fifo_cmt #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CREDIT_WIDTH(CW)) dut (
        .tlx_clk                     (tlx_clk),
        .reset_n                     (reset_n),
        .wr_valid                    (wr_valid),
        .wr_data                     (wr_data),
        .commit                      (commit),
        .crc_error                   (crc_error),
        .afu_tlx_resp_initial_credit (init_cred),
        .afu_tlx_resp_credit         (afu_ret),
        .tlx_afu_valid               (tlx_afu_valid),
        .tlx_afu_resp_data           (tlx_afu_resp_data),
        .rcv_xmt_credit_v            (rcv_xmt_credit_v),
        .occupancy                   (occupancy),
        .fifo_overflow_err           (fifo_overflow_err),
        .credit_overflow_err         (credit_overflow_err)
    );

    always #5 tlx_clk = ~tlx_clk;

    // Reference model: committed and pending entries as queues, credits as plain counts
    logic [DW-1:0] m_cq[$];
    logic [DW-1:0] m_pq[$];
    int            m_cred;
    int            m_owed;
    bit            m_valid, m_cv, m_fovf, m_covf;
    logic [DW-1:0] m_data;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit            wv;
        logic [DW-1:0] wd;
        bit            cm;
        bit            crc;
        int            occ;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset(input int init);
        m_cq.delete();
        m_pq.delete();
        m_cred  = init;
        m_owed  = DEPTH;
        m_valid = 1'b0;
        m_cv    = 1'b0;
        m_fovf  = 1'b0;
        m_covf  = 1'b0;
        m_data  = '0;
    endtask

    task automatic model_step(input bit wv, input logic [DW-1:0] wd, input bit cm,
                              input bit crc, input bit ret);
        int occ;
        bit rd;
        occ = m_cq.size() + m_pq.size();
        rd  = (m_cq.size() > 0) && (m_cred > 0);
        m_cv = (m_owed > 0);
        m_owed = m_owed + int'(rd) - ((m_owed > 0) ? 1 : 0);
        m_valid = rd;
        if (rd) m_data = m_cq.pop_front();
        if (wv && occ == DEPTH) m_fovf = 1'b1;
        else if (wv && !crc) m_pq.push_back(wd);
        if (crc) m_pq.delete();
        else if (cm) begin
            for (int i = 0; i < m_pq.size(); i++) m_cq.push_back(m_pq[i]);
            m_pq.delete();
        end
        if (ret && !rd && m_cred == CMAX) m_covf = 1'b1;
        else m_cred = m_cred + int'(ret) - int'(rd);
    endtask

    task automatic check_all();
        chk("valid", tlx_afu_valid, m_valid);
        chk("resp_data", tlx_afu_resp_data, m_data);
        chk("credit_v", rcv_xmt_credit_v, m_cv);
        chk("occupancy", occupancy, m_cq.size() + m_pq.size());
        chk("fifo_ovf", fifo_overflow_err, m_fovf);
        chk("cred_ovf", credit_overflow_err, m_covf);
    endtask

    task automatic step(input bit wv, input logic [DW-1:0] wd, input bit cm,
                        input bit crc, input bit ret);
        wr_valid  = wv;
        wr_data   = wd;
        commit    = cm;
        crc_error = crc;
        afu_ret   = ret;
        model_step(wv, wd, cm, crc, ret);
        @(posedge tlx_clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int init);
        reset_n   = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        commit    = 1'b0;
        crc_error = 1'b0;
        afu_ret   = 1'b0;
        init_cred = CW'(init);
        for (int i = 0; i < 2; i++) begin
            @(posedge tlx_clk);
            #1;
            chk("rst_valid", tlx_afu_valid, 1'b0);
            chk("rst_data", tlx_afu_resp_data, '0);
            chk("rst_credit_v", rcv_xmt_credit_v, 1'b0);
            chk("rst_occupancy", occupancy, '0);
            chk("rst_fifo_ovf", fifo_overflow_err, 1'b0);
            chk("rst_cred_ovf", credit_overflow_err, 1'b0);
        end
        model_reset(init);
        reset_n = 1'b1;
    endtask

    initial begin
        int            run, first, cnt;
        logic [DW-1:0] got[$];

        tbl[0] = '{1'b1, 56'hA, 1'b0, 1'b0, 1};
        tbl[1] = '{1'b1, 56'hB, 1'b1, 1'b0, 2};
        tbl[2] = '{1'b1, 56'hC, 1'b0, 1'b0, 3};
        tbl[3] = '{1'b1, 56'hD, 1'b0, 1'b0, 4};
        tbl[4] = '{1'b0, 56'h0, 1'b0, 1'b1, 2};
        tbl[5] = '{1'b1, 56'hC, 1'b0, 1'b0, 3};
        tbl[6] = '{1'b1, 56'hD, 1'b1, 1'b0, 4};
        tbl[7] = '{1'b1, 56'hE, 1'b1, 1'b1, 4};
        tbl[8] = '{1'b0, 56'h0, 1'b0, 1'b1, 4};
        tbl[9] = '{1'b0, 56'h0, 1'b0, 1'b0, 4};

        // Initial host credit burst with no traffic
        do_reset(2);
        run = 0;
        first = -1;
        for (int i = 0; i < 132; i++) begin
            idle();
            if (rcv_xmt_credit_v) begin
                if (first < 0) first = i;
                run++;
            end
        end
        chk("init_pulse_count", run, 128);
        chk("init_pulse_start", first, 0);

        // Two AFU credits gate three committed entries
        do_reset(2);
        step(1'b1, 56'd100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 56'd101, 1'b0, 1'b0, 1'b0);
        step(1'b1, 56'd102, 1'b1, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (tlx_afu_valid) cnt++;
        end
        chk("two_credit_pulses", cnt, 2);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("third_after_return", tlx_afu_valid, 1'b1);
        chk("third_data", tlx_afu_resp_data, 56'd102);

        // Commit / rollback vectors, AFU holds all credit so nothing drains
        do_reset(0);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].wv, tbl[i].wd, tbl[i].cm, tbl[i].crc, 1'b0);
            chk($sformatf("tbl_occ[%0d]", i), occupancy, tbl[i].occ);
        end
        got.delete();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b0, 1'b0, (i < 4) ? 1'b1 : 1'b0);
            if (tlx_afu_valid) got.push_back(tlx_afu_resp_data);
        end
        chk("rollback_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++)
            chk($sformatf("rollback_data[%0d]", i), got[i], 56'hA + 56'(i));

        // Fill, overflow, drain, then random traffic across the pointer wrap
        do_reset(0);
        for (int i = 0; i < 129; i++) step(1'b1, DW'(i + 1000), 1'b1, 1'b0, 1'b0);
        chk("full_overflow_flag", fifo_overflow_err, 1'b1);
        chk("full_occupancy", occupancy, 128);
        cnt = 0;
        for (int i = 0; i < 138; i++) begin
            step(1'b0, '0, 1'b0, 1'b0, (i < 128) ? 1'b1 : 1'b0);
            if (rcv_xmt_credit_v) cnt++;
        end
        chk("drain_pulses", cnt, 128);
        chk("drain_empty", occupancy, 0);
        for (int i = 0; i < 450; i++)
            step(($urandom % 4) != 0, DW'({$urandom(), $urandom()}), ($urandom % 3) == 0,
                 ($urandom % 20) == 0, ($urandom % 2) == 1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b0, '0, 1'b0, 1'b0, ($urandom % 2) == 1);
        chk("random_drained", occupancy, 0);

        // AFU credit saturation
        do_reset(127);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("cred_saturate_flag", credit_overflow_err, 1'b1);
        step(1'b1, 56'h55, 1'b1, 1'b0, 1'b0);
        idle();
        idle();

        // Reset while a read is in flight
        do_reset(3);
        step(1'b1, 56'h1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 56'h2, 1'b1, 1'b0, 1'b0);
        idle();
        do_reset(3);
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
